// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port SRAM-style bus (req / addr_ok / data_ok) between the
// fetch port and the MEM-stage data port, one transaction in flight, data first.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | no transaction; ports may be accepted (data wins a tie)
//   S_I_ADDR | fetch accepted, mem_req held until mem_addr_ok
//   S_I_WAIT | fetch address taken, waiting for mem_data_ok
//   S_D_ADDR | load/store accepted, mem_req held until mem_addr_ok
//   S_D_WAIT | load/store address taken, waiting for mem_data_ok
module sram_port_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush_i,
   input  logic            inst_req_i,
   input  logic [AW-1:0]   inst_addr_i,
   output logic            inst_addr_ok_o,
   output logic            inst_data_ok_o,
   output logic [DW-1:0]   inst_rdata_o,
   input  logic            data_req_i,
   input  logic            data_wr_i,
   input  logic [DW/8-1:0] data_wstrb_i,
   input  logic [AW-1:0]   data_addr_i,
   input  logic [DW-1:0]   data_wdata_i,
   output logic            data_addr_ok_o,
   output logic            data_data_ok_o,
   output logic [DW-1:0]   data_rdata_o,
   output logic            mem_req_o,
   output logic            mem_wr_o,
   output logic [DW/8-1:0] mem_wstrb_o,
   output logic [AW-1:0]   mem_addr_o,
   output logic [DW-1:0]   mem_wdata_o,
   input  logic            mem_addr_ok_i,
   input  logic            mem_data_ok_i,
   input  logic [DW-1:0]   mem_rdata_i,
   output logic            stallreq_inst_o,
   output logic            stallreq_data_o
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_I_ADDR = 3'd1;
   localparam logic [2:0] S_I_WAIT = 3'd2;
   localparam logic [2:0] S_D_ADDR = 3'd3;
   localparam logic [2:0] S_D_WAIT = 3'd4;

   logic [2:0]      state_q, state_d;
   logic            mem_wr_q, mem_wr_d;
   logic [DW/8-1:0] mem_wstrb_q, mem_wstrb_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
   logic            cancel_q, cancel_d;

   logic idle, in_inst, in_data, inst_fin, data_fin;
   logic inst_acc, data_acc;

   assign idle     = (state_q == S_IDLE);
   assign in_inst  = (state_q == S_I_ADDR) | (state_q == S_I_WAIT);
   assign in_data  = (state_q == S_D_ADDR) | (state_q == S_D_WAIT);
   assign inst_fin = (state_q == S_I_WAIT) & mem_data_ok_i;
   assign data_fin = (state_q == S_D_WAIT) & mem_data_ok_i;

   // Accepts are masked during reset so nothing is handshaken that the FSM will not track.
   assign data_acc = ~rst & idle & data_req_i;
   assign inst_acc = ~rst & idle & inst_req_i & ~data_req_i;

   assign data_addr_ok_o = data_acc;
   assign inst_addr_ok_o = inst_acc;

   assign mem_req_o   = (state_q == S_I_ADDR) | (state_q == S_D_ADDR);
   assign mem_wr_o    = mem_wr_q;
   assign mem_wstrb_o = mem_wstrb_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

   // A cancelled fetch still finishes on the bus; only its response is swallowed.
   assign inst_data_ok_o = ~rst & inst_fin & ~cancel_q;
   assign data_data_ok_o = ~rst & data_fin;
   assign inst_rdata_o   = inst_data_ok_o ? mem_rdata_i : '0;
   assign data_rdata_o   = data_data_ok_o ? mem_rdata_i : '0;

   assign stallreq_data_o = (data_req_i & ~data_addr_ok_o) | (in_data & ~data_fin);
   assign stallreq_inst_o = ~cancel_q &
                            ((inst_req_i & ~inst_addr_ok_o) | (in_inst & ~inst_fin));

   always_comb begin
      state_d     = state_q;
      mem_wr_d    = mem_wr_q;
      mem_wstrb_d = mem_wstrb_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cancel_d    = cancel_q;
      case (state_q)
         S_IDLE: begin
            if (data_acc) begin
               state_d     = S_D_ADDR;
               mem_wr_d    = data_wr_i;
               mem_wstrb_d = data_wstrb_i;
               mem_addr_d  = data_addr_i;
               mem_wdata_d = data_wdata_i;
            end else if (inst_acc) begin
               state_d     = S_I_ADDR;
               mem_wr_d    = 1'b0;
               mem_wstrb_d = '0;
               mem_addr_d  = inst_addr_i;
               mem_wdata_d = '0;
            end
         end
         S_I_ADDR: if (mem_addr_ok_i) state_d = S_I_WAIT;
         S_I_WAIT: if (mem_data_ok_i) state_d = S_IDLE;
         S_D_ADDR: if (mem_addr_ok_i) state_d = S_D_WAIT;
         S_D_WAIT: if (mem_data_ok_i) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      if (in_inst & flush_i) cancel_d = 1'b1;
      if (inst_fin)          cancel_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mem_wr_q    <= 1'b0;
         mem_wstrb_q <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cancel_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_wr_q    <= mem_wr_d;
         mem_wstrb_q <= mem_wstrb_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cancel_q    <= cancel_d;
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus random traffic, checked each
// cycle against a transaction-level model and a word memory seen through the bus.
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst, flush, inst_req, data_req, data_wr, mem_addr_ok, mem_data_ok;
   logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
   logic [3:0]  data_wstrb;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic        mem_req, mem_wr, stallreq_inst, stallreq_data;
   logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;

   always #5 clk = ~clk;

   sram_port_arbiter #(.AW(32), .DW(32)) dut (
      .clk(clk), .rst(rst), .flush_i(flush),
      .inst_req_i(inst_req), .inst_addr_i(inst_addr),
      .inst_addr_ok_o(inst_addr_ok), .inst_data_ok_o(inst_data_ok), .inst_rdata_o(inst_rdata),
      .data_req_i(data_req), .data_wr_i(data_wr), .data_wstrb_i(data_wstrb),
      .data_addr_i(data_addr), .data_wdata_i(data_wdata),
      .data_addr_ok_o(data_addr_ok), .data_data_ok_o(data_data_ok), .data_rdata_o(data_rdata),
      .mem_req_o(mem_req), .mem_wr_o(mem_wr), .mem_wstrb_o(mem_wstrb),
      .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_addr_ok_i(mem_addr_ok), .mem_data_ok_i(mem_data_ok), .mem_rdata_i(mem_rdata),
      .stallreq_inst_o(stallreq_inst), .stallreq_data_o(stallreq_data)
   );

   int n_tests = 0, n_fail = 0;

   // ref_mem follows accepted port requests; bus_mem follows what the DUT puts on the bus.
   logic [31:0] ref_mem [16];
   logic [31:0] bus_mem [16];

   bit          busy, own_d, addr_done, cancel;
   bit          r_wr;
   logic [3:0]  r_wstrb;
   logic [31:0] r_addr, r_wdata, exp_rd, resp_data;
   int          ma_wait, rd_wait, lat_a, lat_d;
   bit          rand_mode, rand_lat, stray_en, force_mdok, d_pend, i_pend;

   bit          s_iao, s_dao, s_iok, s_dok, s_mreq, s_si, s_sd, s_mwr;
   logic [31:0] s_ird, s_drd, s_maddr, s_mwdata;
   logic [3:0]  s_mwstrb;
   int          n_iok, n_dok;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic int widx(input logic [31:0] a);
      return int'(a[5:2]);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] st);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
      return r;
   endfunction

   // One clock cycle: drive memory side, sample at negedge+1, check, advance the model.
   task automatic step();
      bit comp, e_dao, e_iao, e_mreq, e_idok, e_ddok;
      logic [31:0] e_drd, e_ird;
      if (rand_mode) begin
         if (!d_pend && $urandom_range(0, 3) == 0) begin
            d_pend     = 1'b1;
            data_wr    = ($urandom_range(0, 2) == 0);
            data_wstrb = 4'($urandom_range(1, 15));
            data_addr  = 32'h8000_0000 + 32'($urandom_range(0, 15)) * 4;
            data_wdata = $urandom;
         end
         if (!i_pend && $urandom_range(0, 2) == 0) begin
            i_pend    = 1'b1;
            inst_addr = 32'hBFC0_0000 + 32'($urandom_range(0, 15)) * 4;
         end
         data_req = d_pend;
         inst_req = i_pend;
      end
      if (busy && !addr_done) mem_addr_ok = (ma_wait == 0);
      else                    mem_addr_ok = 1'($urandom_range(0, 1));
      if (busy && addr_done) begin
         mem_data_ok = (rd_wait == 0);
         mem_rdata   = mem_data_ok ? resp_data : $urandom;
      end else begin
         mem_data_ok = force_mdok || (stray_en && $urandom_range(0, 7) == 0);
         mem_rdata   = $urandom;
      end
      comp = !rst && busy && addr_done && mem_data_ok;
      if (rand_mode) flush = ($urandom_range(0, 9) == 0) && !comp;
      #1;
      s_iao = inst_addr_ok;  s_dao = data_addr_ok;  s_iok = inst_data_ok;  s_dok = data_data_ok;
      s_ird = inst_rdata;    s_drd = data_rdata;    s_mreq = mem_req;
      s_si  = stallreq_inst; s_sd  = stallreq_data;
      s_mwr = mem_wr; s_maddr = mem_addr; s_mwdata = mem_wdata; s_mwstrb = mem_wstrb;

      e_dao  = !busy && data_req;
      e_iao  = !busy && inst_req && !data_req;
      e_mreq = busy && !addr_done;
      e_ddok = comp && own_d;
      e_idok = comp && !own_d && !cancel;
      e_drd  = e_ddok ? (r_wr ? mem_rdata : exp_rd) : 32'h0;
      e_ird  = e_idok ? exp_rd : 32'h0;

      check_eq("mem_req", 32'(s_mreq), 32'(e_mreq));
      if (rst) begin
         check_eq("rst_addr_ok", {s_iao, s_dao}, 0);
         check_eq("rst_data_ok", {s_iok, s_dok}, 0);
      end else begin
         check_eq("data_addr_ok", 32'(s_dao), 32'(e_dao));
         check_eq("inst_addr_ok", 32'(s_iao), 32'(e_iao));
         check_eq("data_data_ok", 32'(s_dok), 32'(e_ddok));
         check_eq("inst_data_ok", 32'(s_iok), 32'(e_idok));
         check_eq("data_rdata", s_drd, e_drd);
         check_eq("inst_rdata", s_ird, e_ird);
         check_eq("stallreq_data", 32'(s_sd),
                  32'((data_req && !e_dao) || (busy && own_d && !comp)));
         check_eq("stallreq_inst", 32'(s_si),
                  32'(!cancel && ((inst_req && !e_iao) || (busy && !own_d && !comp))));
         if (e_mreq) begin
            check_eq("mem_addr", s_maddr, r_addr);
            check_eq("mem_wr", 32'(s_mwr), 32'(r_wr));
            check_eq("mem_wstrb", 32'(s_mwstrb), 32'(r_wstrb));
            if (own_d && r_wr) check_eq("mem_wdata", s_mwdata, r_wdata);
         end
      end
      if (s_iok) n_iok++;
      if (s_dok) n_dok++;

      @(posedge clk);
      if (rst) begin
         busy = 0; addr_done = 0; cancel = 0;
      end else begin
         if (busy && !own_d && flush && !comp) cancel = 1;
         if (busy && !addr_done) begin
            if (mem_addr_ok) begin
               addr_done = 1;
               if (s_mwr) begin
                  bus_mem[widx(s_maddr)] = merge(bus_mem[widx(s_maddr)], s_mwdata, s_mwstrb);
                  resp_data = $urandom;
               end else begin
                  resp_data = bus_mem[widx(s_maddr)];
               end
            end else begin
               ma_wait--;
            end
         end else if (busy) begin
            if (comp) begin busy = 0; addr_done = 0; cancel = 0; end
            else rd_wait--;
         end else if (e_dao || e_iao) begin
            busy = 1; addr_done = 0; own_d = e_dao;
            if (e_dao) begin
               r_wr = data_wr; r_wstrb = data_wstrb; r_addr = data_addr; r_wdata = data_wdata;
               if (data_wr) ref_mem[widx(data_addr)] = merge(ref_mem[widx(data_addr)], data_wdata, data_wstrb);
               else         exp_rd = ref_mem[widx(data_addr)];
               d_pend = 0;
            end else begin
               r_wr = 0; r_wstrb = 4'h0; r_addr = inst_addr; r_wdata = 32'h0;
               exp_rd = ref_mem[widx(inst_addr)];
               i_pend = 0;
            end
            ma_wait = rand_lat ? $urandom_range(0, 2) : lat_a;
            rd_wait = rand_lat ? $urandom_range(0, 2) : lat_d;
         end
      end
      @(negedge clk);
   endtask

   task automatic wait_dok(input string tag);
      int k = 0;
      do begin step(); k++; end while (!s_dok && k < 40);
      check_eq(tag, 32'(s_dok), 32'h1);
   endtask

   task automatic wait_iok(input string tag);
      int k = 0;
      do begin step(); k++; end while (!s_iok && k < 40);
      check_eq(tag, 32'(s_iok), 32'h1);
   endtask

   initial begin
      logic [31:0] old, exp_q[$];
      int got, issued, k;
      rst = 1; flush = 0; inst_req = 0; data_req = 0; data_wr = 0; data_wstrb = 0;
      inst_addr = 0; data_addr = 0; data_wdata = 0;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
      busy = 0; own_d = 0; addr_done = 0; cancel = 0; ma_wait = 0; rd_wait = 0;
      r_wr = 0; r_wstrb = 0; r_addr = 0; r_wdata = 0; exp_rd = 0; resp_data = 0;
      rand_mode = 0; rand_lat = 0; stray_en = 0; force_mdok = 0; d_pend = 0; i_pend = 0;
      lat_a = 0; lat_d = 0; n_iok = 0; n_dok = 0;
      for (int i = 0; i < 16; i++) begin ref_mem[i] = $urandom; bus_mem[i] = ref_mem[i]; end

      @(negedge clk);
      step(); step();
      rst = 0;
      step();
      check_eq("reset_mem_addr", s_maddr, 32'h0);
      check_eq("reset_mem_wr_wstrb", {s_mwr, s_mwstrb}, 0);
      check_eq("reset_mem_wdata", s_mwdata, 32'h0);
      check_eq("reset_stalls", {s_si, s_sd}, 0);

      // Best-case fetch
      ref_mem[0] = 32'h2408_0001; bus_mem[0] = 32'h2408_0001;
      inst_req = 1; inst_addr = 32'hBFC0_0000;
      step();
      check_eq("fetch_c0_addr_ok", 32'(s_iao), 32'h1);
      check_eq("fetch_c0_stall", 32'(s_si), 32'h0);
      inst_req = 0;
      step();
      check_eq("fetch_c1_mem_req", 32'(s_mreq), 32'h1);
      check_eq("fetch_c1_stall", 32'(s_si), 32'h1);
      step();
      check_eq("fetch_c2_data_ok", 32'(s_iok), 32'h1);
      check_eq("fetch_c2_rdata", s_ird, 32'h2408_0001);
      check_eq("fetch_c2_stall", 32'(s_si), 32'h0);

      // Same-cycle tie: data wins, fetch waits for the next IDLE cycle
      inst_req = 1; inst_addr = 32'hBFC0_0004;
      data_req = 1; data_wr = 0; data_wstrb = 0; data_addr = 32'h8000_0010; data_wdata = 0;
      step();
      check_eq("tie_data_first", {s_dao, s_iao}, 32'h2);
      data_req = 0;
      wait_dok("tie_data_ok");
      check_eq("tie_load_rdata", s_drd, ref_mem[4]);
      step();
      check_eq("tie_inst_after", 32'(s_iao), 32'h1);
      inst_req = 0;
      wait_iok("tie_inst_ok");

      // Store held through three cycles of address back-pressure
      lat_a = 3; lat_d = 0; old = ref_mem[8];
      data_req = 1; data_wr = 1; data_wstrb = 4'b0100; data_addr = 32'h8000_0020;
      data_wdata = 32'h00AB_0000;
      k = n_dok;
      step();
      check_eq("store_accept", 32'(s_dao), 32'h1);
      data_req = 0; data_wr = 0; data_wdata = 0; data_wstrb = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         check_eq("store_hold_req", 32'(s_mreq), 32'h1);
         check_eq("store_hold_wr_wstrb", {s_mwr, s_mwstrb}, 32'h14);
         check_eq("store_hold_addr", s_maddr, 32'h8000_0020);
         check_eq("store_hold_wdata", s_mwdata, 32'h00AB_0000);
      end
      for (int c = 0; c < 6; c++) step();
      check_eq("store_dok_pulses", 32'(n_dok - k), 32'h1);
      lat_a = 0;
      data_req = 1; data_addr = 32'h8000_0020;
      step();
      data_req = 0;
      wait_dok("store_readback_ok");
      check_eq("store_readback", s_drd, (old & 32'hFF00_FFFF) | 32'h00AB_0000);

      // Flush while the fetch waits for data
      lat_a = 0; lat_d = 2;
      inst_req = 1; inst_addr = 32'hBFC0_0008;
      step();
      inst_req = 0;
      step();
      flush = 1; step(); flush = 0;
      step();
      check_eq("flush_stall_inst", 32'(s_si), 32'h0);
      k = n_iok;
      step();
      check_eq("flush_no_data_ok", 32'(n_iok - k), 32'h0);
      lat_d = 0;
      inst_req = 1; inst_addr = 32'hBFC0_000C;
      step();
      check_eq("flush_next_accept", 32'(s_iao), 32'h1);
      inst_req = 0;
      wait_iok("flush_next_ok");
      check_eq("flush_next_rdata", s_ird, ref_mem[3]);

      // Four back-to-back loads with random memory latency
      rand_lat = 1; got = 0; issued = 0; k = 0;
      for (int i = 0; i < 4; i++) exp_q.push_back(ref_mem[1 + 4 * i]);
      data_req = 1; data_wr = 0; data_addr = 32'h8000_0004;
      while (got < 4 && k < 200) begin
         step(); k++;
         if (s_dok && exp_q.size() > 0) begin
            check_eq("b2b_rdata", s_drd, exp_q.pop_front());
            got++;
         end
         if (s_dao) begin
            issued++;
            if (issued < 4) data_addr = 32'h8000_0004 + 32'(issued) * 16;
            else            data_req = 0;
         end
      end
      check_eq("b2b_count", 32'(got), 32'h4);

      // Reset in D_ADDR, then a stale mem_data_ok
      rand_lat = 0; lat_a = 5; lat_d = 0;
      data_req = 1; data_addr = 32'h8000_0030;
      step();
      data_req = 0;
      step();
      check_eq("rst_pre_mem_req", 32'(s_mreq), 32'h1);
      rst = 1; step(); rst = 0;
      lat_a = 0; force_mdok = 1;
      data_req = 1; data_addr = 32'h8000_0034;
      step();
      force_mdok = 0; data_req = 0;
      check_eq("rst_post_mem_req", 32'(s_mreq), 32'h0);
      check_eq("rst_post_no_dok", 32'(s_dok), 32'h0);
      check_eq("rst_post_idle_accept", 32'(s_dao), 32'h1);
      wait_dok("rst_post_load_ok");
      check_eq("rst_post_load_rdata", s_drd, ref_mem[13]);

      // Random traffic with stray responses and flushes
      rand_mode = 1; rand_lat = 1; stray_en = 1;
      for (int i = 0; i < 1500; i++) step();
      rand_mode = 0; stray_en = 0; flush = 0; data_req = 0; inst_req = 0;
      for (int i = 0; i < 20; i++) step();
      for (int i = 0; i < 16; i++) check_eq("final_mem", bus_mem[i], ref_mem[i]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
